// File: rtl/seven_seg_scanner.sv
// Time-multiplexed common-anode 7-segment scanner with per-frame snapshot,
// blank/blink/dp masks, leading-zero suppression and PWM brightness.
module seven_seg_scanner #(
    parameter int N_DIGITS    = 8,
    parameter int REFRESH_DIV = 131072,
    parameter int BLINK_DIV   = 64,
    parameter int BRIGHT_W    = 3
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [4*N_DIGITS-1:0] digits,
    input  logic [N_DIGITS-1:0]   blank_mask,
    input  logic [N_DIGITS-1:0]   blink_mask,
    input  logic [N_DIGITS-1:0]   dp_mask,
    input  logic                  lzs_en,
    input  logic [BRIGHT_W-1:0]   bright,
    output logic [6:0]            seg_n,
    output logic                  dp_n,
    output logic [N_DIGITS-1:0]   anode_n,
    output logic                  frame_start
);

    localparam int PRE_W = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
    localparam int IDX_W = $clog2(N_DIGITS);
    localparam int BLK_W = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;

    localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(REFRESH_DIV - 1);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(N_DIGITS - 1);
    localparam logic [BLK_W-1:0] BLK_LAST = BLK_W'(BLINK_DIV - 1);

    logic [PRE_W-1:0]    pre_cnt;
    logic [IDX_W-1:0]    idx;
    logic [BLK_W-1:0]    blink_cnt;
    logic                blink_phase;
    logic [BRIGHT_W-1:0] pwm_cnt;
    logic                tick;
    logic                wrap;

    logic [3:0]          shadow_digit [N_DIGITS];
    logic [N_DIGITS-1:0] shadow_blank;
    logic [N_DIGITS-1:0] shadow_blink;
    logic [N_DIGITS-1:0] shadow_dp;
    logic                shadow_lzs;

    logic [N_DIGITS-1:0] suppressed;
    logic                zero_run;
    logic                lit_pwm;
    logic                dark;
    logic [3:0]          cur_digit;
    logic [N_DIGITS-1:0] anode_sel;

    function automatic logic [6:0] decode(input logic [3:0] value);
        logic [6:0] pattern;
        case (value)
            4'h0:    pattern = 7'h01;
            4'h1:    pattern = 7'h4F;
            4'h2:    pattern = 7'h12;
            4'h3:    pattern = 7'h06;
            4'h4:    pattern = 7'h4C;
            4'h5:    pattern = 7'h24;
            4'h6:    pattern = 7'h20;
            4'h7:    pattern = 7'h0F;
            4'h8:    pattern = 7'h00;
            4'h9:    pattern = 7'h04;
            4'hA:    pattern = 7'h08;
            4'hB:    pattern = 7'h60;
            4'hC:    pattern = 7'h31;
            4'hD:    pattern = 7'h42;
            4'hE:    pattern = 7'h30;
            default: pattern = 7'h38;
        endcase
        return pattern;
    endfunction

    assign tick = (pre_cnt == PRE_LAST);
    assign wrap = tick && (idx == IDX_LAST);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pre_cnt <= '0;
        end else if (tick) begin
            pre_cnt <= '0;
        end else begin
            pre_cnt <= pre_cnt + PRE_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            idx <= '0;
        end else if (tick) begin
            idx <= wrap ? '0 : idx + IDX_W'(1);
        end
    end

    // PWM restarts at every slot so each digit gets the same on-time window.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pwm_cnt <= '0;
        end else if (tick) begin
            pwm_cnt <= '0;
        end else begin
            pwm_cnt <= pwm_cnt + BRIGHT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            blink_cnt   <= '0;
            blink_phase <= 1'b0;
        end else if (wrap) begin
            if (blink_cnt == BLK_LAST) begin
                blink_cnt   <= '0;
                blink_phase <= ~blink_phase;
            end else begin
                blink_cnt <= blink_cnt + BLK_W'(1);
            end
        end
    end

    // Shadow blank resets to all ones so nothing lights before the first snapshot.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < N_DIGITS; i++) begin
                shadow_digit[i] <= 4'h0;
            end
            shadow_blank <= '1;
            shadow_blink <= '0;
            shadow_dp    <= '0;
            shadow_lzs   <= 1'b0;
            frame_start  <= 1'b0;
        end else begin
            frame_start <= wrap;
            if (wrap) begin
                for (int i = 0; i < N_DIGITS; i++) begin
                    shadow_digit[i] <= digits[4*i +: 4];
                end
                shadow_blank <= blank_mask;
                shadow_blink <= blink_mask;
                shadow_dp    <= dp_mask;
                shadow_lzs   <= lzs_en;
            end
        end
    end

    // A digit is a leading zero while every digit to its left is also zero.
    always_comb begin
        zero_run   = 1'b1;
        suppressed = '0;
        for (int i = 0; i < N_DIGITS - 1; i++) begin
            zero_run      = zero_run & (shadow_digit[i] == 4'h0);
            suppressed[i] = shadow_lzs & zero_run;
        end
    end

    always_comb begin
        lit_pwm   = (&bright) || (pwm_cnt < bright);
        cur_digit = shadow_digit[idx];
        dark      = shadow_blank[idx]
                  | (shadow_blink[idx] & blink_phase)
                  | suppressed[idx]
                  | ~lit_pwm;
        anode_sel = '1;
        for (int i = 0; i < N_DIGITS; i++) begin
            if (idx == IDX_W'(i)) begin
                anode_sel[N_DIGITS-1-i] = 1'b0;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            seg_n   <= 7'h7F;
            dp_n    <= 1'b1;
            anode_n <= '1;
        end else if (dark) begin
            seg_n   <= 7'h7F;
            dp_n    <= 1'b1;
            anode_n <= '1;
        end else begin
            seg_n   <= decode(cur_digit);
            dp_n    <= ~shadow_dp[idx];
            anode_n <= anode_sel;
        end
    end

endmodule
